multi_clock_divider: RTL

Parametrised successor to the fixed 1 kHz/1 Hz divider. Generates NCH independent divided clocks from the 100 MHz system clock. Each channel provides a 50%-duty square output and a one-cycle tick pulse. Each divisor is reprogrammable at runtime and takes effect glitch-free at the channel's period boundary. Feeds the 7-seg refresh logic, counter16 auto-count, and per-level game timing.

---
 rtl/multi_clock_divider.sv | 95 +++++++++
 1 files changed

// File: rtl/multi_clock_divider.sv
// NCH independent programmable clock dividers with 50%-duty square and one-cycle tick outputs.
// Divisor writes are held pending and take effect at the channel's period boundary.
module multi_clock_divider #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W = 32,
  parameter logic [NCH*W-1:0] DIV_RESET = {32'd0, 32'd0, 32'd100000000, 32'd100000},
  parameter int unsigned SELW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  en,
  input  logic            sync_clear,
  input  logic            cfg_we,
  input  logic [SELW-1:0] cfg_sel,
  input  logic [W-1:0]    cfg_div,
  output logic [NCH-1:0]  sq_o,
  output logic [NCH-1:0]  tick_o,
  output logic [NCH-1:0]  pend_o
);

  logic [W-1:0] cnt_q  [NCH];
  logic [W-1:0] cnt_d  [NCH];
  logic [W-1:0] div_q  [NCH];
  logic [W-1:0] div_d  [NCH];
  logic [W-1:0] pdiv_q [NCH];
  logic [W-1:0] pdiv_d [NCH];
  logic [W-1:0] div_m1 [NCH];
  logic [W:0]   half   [NCH];

  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] sq_q, sq_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] run, wrap, apply;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      run[i]    = en[i] && (div_q[i] != '0);
      div_m1[i] = (div_q[i] != '0) ? div_q[i] - W'(1) : '0;
      // Equality only: a freshly applied smaller divisor can never be overrun.
      wrap[i]   = run[i] && (cnt_q[i] == div_m1[i]);
      apply[i]  = pend_q[i] && (!run[i] || sync_clear || wrap[i]);
      div_d[i]  = apply[i] ? pdiv_q[i] : div_q[i];
      // W+1 bits so an all-ones divisor does not overflow.
      half[i]   = ({1'b0, div_d[i]} + (W+1)'(1)) >> 1;

      pdiv_d[i] = pdiv_q[i];
      pend_d[i] = pend_q[i] && !apply[i];
      if (cfg_we && (int'(cfg_sel) == i)) begin
        pdiv_d[i] = cfg_div;
        pend_d[i] = 1'b1;
      end

      cnt_d[i]  = '0;
      tick_d[i] = 1'b0;
      sq_d[i]   = 1'b0;
      if (run[i]) begin
        if (sync_clear) begin
          cnt_d[i] = '0;
        end else if (wrap[i]) begin
          tick_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + W'(1);
        end
        sq_d[i] = ({1'b0, cnt_d[i]} < half[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_RESET[i*W +: W];
        pdiv_q[i] <= '0;
      end
      pend_q <= '0;
      sq_q   <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
      pend_q <= pend_d;
      sq_q   <= sq_d;
      tick_q <= tick_d;
    end
  end

  assign sq_o   = sq_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule
